// File: rtl/i2fl32_seq.sv
// i2fl32_seq: multi-cycle 32-bit integer to IEEE-754 binary32 converter.
// Normalises one bit per cycle and rounds to nearest-even.
// Valid/ready on both sides; one conversion in flight at a time.
module i2fl32_seq #(
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    // Exponent of a mantissa whose leading one sits in bit 31.
    localparam logic [7:0] EXP_TOP = 8'(EXP_BIAS + 31);

    state_t      state;
    state_t      state_next;
    logic        sign_r;
    logic [31:0] mant_r;
    logic [7:0]  exp_r;
    logic [31:0] out_data_r;

    logic        in_sign;
    logic [31:0] in_mag;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        inc;
    logic [24:0] rounded;
    logic [7:0]  exp_final;
    logic [22:0] frac_final;

    // Split the incoming operand into sign and unsigned magnitude.
    always_comb begin
        in_sign = in_signed & in_data[31];
        in_mag  = in_sign ? (~in_data + 32'd1) : in_data;
    end

    // Round-to-nearest-even of the normalised mantissa; a carry out of
    // the 24-bit significand leaves bit 23 clear and bumps the exponent.
    always_comb begin
        guard      = mant_r[7];
        sticky     = |mant_r[6:0];
        lsb        = mant_r[8];
        inc        = guard & (sticky | lsb);
        rounded    = {1'b0, mant_r[31:8]} + {24'd0, inc};
        exp_final  = exp_r + {7'd0, rounded[24]};
        frac_final = rounded[23] ? rounded[22:0] : 23'd0;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (in_mag == 32'd0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mant_r[31]) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture, shift-normalise, and register the packed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r     <= 1'b0;
            mant_r     <= 32'd0;
            exp_r      <= 8'd0;
            out_data_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        mant_r <= in_mag;
                        exp_r  <= EXP_TOP;
                        if (in_mag == 32'd0) begin
                            out_data_r <= 32'd0;
                        end
                    end
                end
                NORM: begin
                    if (!mant_r[31]) begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 8'd1;
                    end
                end
                ROUND: begin
                    out_data_r <= {sign_r, exp_final, frac_final};
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = out_data_r;

endmodule

// File: tb/tb_i2fl32_seq.sv
// tb_i2fl32_seq: self-checking bench for i2fl32_seq.
// Expected results come from a double-precision reference rounded to binary32.
module tb_i2fl32_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    i2fl32_seq #(.EXP_BIAS(127)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer -> double, then round the 52-bit fraction to 23 bits (RNE).
    function automatic logic [31:0] ref_convert(input logic [31:0] d, input logic s);
        longint      v;
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        logic [22:0] f;
        logic [28:0] rem;
        logic        up;
        logic [30:0] body;
        v = s ? longint'($signed(d)) : longint'({32'd0, d});
        if (v == 0) return 32'd0;
        r    = real'(v);
        b    = $realtobits(r);
        e    = b[62:52];
        f    = b[51:29];
        rem  = b[28:0];
        up   = (rem > 29'h10000000) || ((rem == 29'h10000000) && f[0]);
        body = {8'(e - 11'd896), f} + {30'd0, up};
        return {b[63], body};
    endfunction

    // Drive one operand, measure latency (accept edge counts as 1), collect and drain the result.
    task automatic run_conversion(input logic [31:0] d, input logic s,
                                  output logic [31:0] res, output int lat);
        int wait_cnt;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_data !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_data got %h want 00000000", out_data);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [31:0] expect_data;
        int          expect_lat;
    } vec_t;

    task automatic test_directed();
        vec_t        vecs[8];
        logic [31:0] res;
        int          lat;
        vecs[0] = '{32'h00000001, 1'b0, 32'h3F800000, 34};
        vecs[1] = '{32'h00000000, 1'b1, 32'h00000000, 1};
        vecs[2] = '{32'hFFFFFFFE, 1'b1, 32'hC0000000, 33};
        vecs[3] = '{32'h80000000, 1'b1, 32'hCF000000, 3};
        vecs[4] = '{32'h80000000, 1'b0, 32'h4F000000, 3};
        vecs[5] = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 3};
        vecs[6] = '{32'h01000001, 1'b0, 32'h4B800000, 10};
        vecs[7] = '{32'h01000003, 1'b0, 32'h4B800002, 10};
        for (int i = 0; i < 8; i++) begin
            run_conversion(vecs[i].data, vecs[i].sgn, res, lat);
            tests_run++;
            if (res !== vecs[i].expect_data) begin
                tests_failed++;
                $display("[TB] FAIL directed_data[%0d] in=%h s=%b got %h want %h",
                         i, vecs[i].data, vecs[i].sgn, res, vecs[i].expect_data);
            end
            tests_run++;
            if (lat !== vecs[i].expect_lat) begin
                tests_failed++;
                $display("[TB] FAIL directed_latency[%0d] in=%h got %0d want %0d",
                         i, vecs[i].data, lat, vecs[i].expect_lat);
            end
        end
    endtask

    task automatic test_handshake();
        int wait_cnt;
        int bad;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'd5;
        in_signed = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1;
                in_data  = 32'h00001234;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid !== 1'b1 || out_data !== 32'h40A00000 || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_cycle[%0d] out_valid=%b out_data=%h in_ready=%b want 1/40a00000/0",
                         i, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests_run++;
        if (bad != 0) tests_failed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL ignored_pulse got %0d busy/valid cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_norm();
        logic [31:0] res;
        int          lat;
        int          stale;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h00000001;
        in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset got in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stale++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("[TB] FAIL stale_output got %0d valid cycles want 0", stale);
        end
        run_conversion(32'h00000003, 1'b0, res, lat);
        tests_run++;
        if (res !== 32'h40400000) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_data got %h want 40400000", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[8];
        logic        sgns[8];
        logic [31:0] expq[$];
        logic [31:0] want;
        int          sent;
        int          recv;
        int          bad;
        int          dup;
        for (int i = 0; i < 8; i++) begin
            sgns[i] = 1'($urandom_range(0, 1));
            vals[i] = $urandom >> $urandom_range(0, 31);
            if (sgns[i] && $urandom_range(0, 1) == 1) vals[i] = -vals[i];
        end
        vals[3] = 32'd0;
        sent = 0;
        recv = 0;
        bad  = 0;
        fork
            begin : producer
                int p_cyc;
                p_cyc = 0;
                while (sent < 8 && p_cyc < 5000) begin
                    @(negedge clk);
                    p_cyc++;
                    if (in_ready) begin
                        in_data   = vals[sent];
                        in_signed = sgns[sent];
                        in_valid  = 1'b1;
                        expq.push_back(ref_convert(vals[sent], sgns[sent]));
                        sent++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : consumer
                int c_cyc;
                c_cyc = 0;
                while (recv < 8 && c_cyc < 5000) begin
                    @(negedge clk);
                    c_cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        want = (expq.size() > 0) ? expq.pop_front() : 32'hxxxxxxxx;
                        if (out_data !== want) begin
                            bad++;
                            $display("[TB] FAIL stream[%0d] got %h want %h", recv, out_data, want);
                        end
                        recv++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (recv != 8 || sent != 8 || expq.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_count got sent=%0d recv=%0d left=%0d want 8/8/0",
                     sent, recv, expq.size());
        end
        dup = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) dup++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (dup != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_duplicate got %0d extra valid cycles want 0", dup);
        end
    endtask

    // Test sequence.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid_norm();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
